// File: rtl/shift_register_univ_p.sv
//------------------------------------------------------------------------------
// Module      : shift_register_univ_p
// Description : WIDTH-bit universal register (load, shift, rotate, arithmetic
//               shift, clear) with a frame-complete pulse every WIDTH shifts.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module shift_register_univ_p #(
    parameter int               WIDTH       = 8,
    parameter logic [WIDTH-1:0] RESET_VALUE = {WIDTH{1'b0}},
    parameter int               CNT_W       = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [2:0]       mode,
    input  logic [WIDTH-1:0] d,
    input  logic             sin_l,
    input  logic             sin_r,
    output logic [WIDTH-1:0] q,
    output logic             sout_l,
    output logic             sout_r,
    output logic             frame_done
);

    localparam logic [2:0] c_HOLD = 3'b000;
    localparam logic [2:0] c_LOAD = 3'b001;
    localparam logic [2:0] c_SHL  = 3'b010;
    localparam logic [2:0] c_SHR  = 3'b011;
    localparam logic [2:0] c_ROL  = 3'b100;
    localparam logic [2:0] c_ROR  = 3'b101;
    localparam logic [2:0] c_ASR  = 3'b110;
    localparam logic [2:0] c_CLR  = 3'b111;

    localparam logic [CNT_W-1:0] c_CNT_LAST = CNT_W'(WIDTH - 1);

    logic [WIDTH-1:0] r_q;
    logic [CNT_W-1:0] r_cnt;
    logic             r_frame_done;
    logic [WIDTH-1:0] w_q_next;
    logic             w_is_shift;
    logic             w_cnt_clear;

    always_comb begin
        w_q_next    = r_q;
        w_is_shift  = 1'b0;
        w_cnt_clear = 1'b0;
        case (mode)
            c_HOLD: w_q_next = r_q;
            c_LOAD: begin
                w_q_next    = d;
                w_cnt_clear = 1'b1;
            end
            c_SHL: begin
                w_q_next   = {r_q[WIDTH-2:0], sin_r};
                w_is_shift = 1'b1;
            end
            c_SHR: begin
                w_q_next   = {sin_l, r_q[WIDTH-1:1]};
                w_is_shift = 1'b1;
            end
            c_ROL: begin
                w_q_next   = {r_q[WIDTH-2:0], r_q[WIDTH-1]};
                w_is_shift = 1'b1;
            end
            c_ROR: begin
                w_q_next   = {r_q[0], r_q[WIDTH-1:1]};
                w_is_shift = 1'b1;
            end
            c_ASR: begin
                w_q_next   = {r_q[WIDTH-1], r_q[WIDTH-1:1]};
                w_is_shift = 1'b1;
            end
            c_CLR: begin
                w_q_next    = {WIDTH{1'b0}};
                w_cnt_clear = 1'b1;
            end
            default: w_q_next = r_q;
        endcase
    end

    // The count survives HOLD and disabled cycles; only LOAD/CLR/reset restart a frame.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_q          <= RESET_VALUE;
            r_cnt        <= '0;
            r_frame_done <= 1'b0;
        end else if (en) begin
            r_q          <= w_q_next;
            r_frame_done <= 1'b0;
            if (w_is_shift) begin
                if (r_cnt == c_CNT_LAST) begin
                    r_cnt        <= '0;
                    r_frame_done <= 1'b1;
                end else begin
                    r_cnt <= r_cnt + CNT_W'(1);
                end
            end else if (w_cnt_clear) begin
                r_cnt <= '0;
            end
        end else begin
            r_frame_done <= 1'b0;
        end
    end

    assign q          = r_q;
    assign sout_l     = r_q[WIDTH-1];
    assign sout_r     = r_q[0];
    assign frame_done = r_frame_done;

endmodule

`default_nettype wire

// File: doc/shift_register_univ_p.md
Name: shift_register_univ_p

Overview:
- Parametrised successor to the single-bit positive-edge D flip-flop: a WIDTH-bit universal register with enable, parallel load, and logical/arithmetic shift and rotate modes.
- Tracks consecutive shifts and pulses a frame-complete flag every WIDTH shifts, for serial-to-parallel and parallel-to-serial conversion.
- Used as the general storage/serialiser primitive for the later SD112 datapath tasks.

Parameters:
- WIDTH, 8, register width in bits; legal range WIDTH >= 2.
- RESET_VALUE, {WIDTH{1'b0}}, value loaded into q on reset.
- CNT_W, $clog2(WIDTH), width of the internal shift counter; derived, do not override.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  reset, synchronous, active-low; sampled on the rising edge of clk.
- en  input  1  clock enable; when 0, all state holds.
- mode  input  3  operation select; encoding given under Behaviour.
- d  input  WIDTH  parallel load data.
- sin_l  input  1  serial input that enters at the MSB on right shifts.
- sin_r  input  1  serial input that enters at the LSB on left shifts.
- q  output  WIDTH  register contents; registered.
- sout_l  output  1  q[WIDTH-1]; combinational from q.
- sout_r  output  1  q[0]; combinational from q.
- frame_done  output  1  one-cycle pulse after WIDTH consecutive shift/rotate operations; registered.

Behaviour:
- Reset:
  - If rst == 0 at a clk rising edge: q <= RESET_VALUE, shift counter <= 0, frame_done <= 0.
  - Reset has priority over en and mode.
  - A reset asserted mid-frame discards the partial count.
- Disabled (en == 0): q and the counter hold; frame_done <= 0.
- Mode encoding when en == 1, taking effect on the next edge (1-cycle latency):
  - 000 HOLD: q holds; counter holds.
  - 001 LOAD: q <= d; counter <= 0.
  - 010 SHL: q <= {q[WIDTH-2:0], sin_r}.
  - 011 SHR: q <= {sin_l, q[WIDTH-1:1]}.
  - 100 ROL: q <= {q[WIDTH-2:0], q[WIDTH-1]}.
  - 101 ROR: q <= {q[0], q[WIDTH-1:1]}.
  - 110 ASR: q <= {q[WIDTH-1], q[WIDTH-1:1]}; the sign bit is replicated and sin_l is ignored.
  - 111 CLR: q <= 0, not RESET_VALUE; counter <= 0.
- Shift counter (modes 010 to 110 are "shift ops"):
  - Each enabled shift op increments the counter.
  - If the counter == WIDTH-1 when a shift op occurs, the counter wraps to 0 and frame_done <= 1 on that same edge. frame_done is therefore high during the cycle in which q first holds the complete frame.
  - frame_done is 0 on every other edge. It never stays high for two cycles unless every edge completes a frame, which is impossible for WIDTH >= 2.
  - HOLD and en == 0 preserve the count. Mixing shift directions or shift/rotate kinds does not reset the count.
  - LOAD and CLR reset the counter to 0, even mid-frame.
- sout_l and sout_r reflect the current q with no extra delay; they change only after clk edges.
- Simultaneous events: rst low together with en/mode means reset wins. Any mode value with en low means hold. There is no undefined mode value.

Test Plan:
- Reset with rst=0 for 2 cycles, en=1, mode=001, d=8'hFF -> q=8'h00, frame_done=0; after rst=1, one more LOAD edge -> q=8'hFF.
- LOAD d=8'hA5, then SHL x8 with sin_r=1 -> q sequence 4B,97,2F,5F,BF,7F,FF,FF; sout_l gives the serial stream 1,0,1,0,0,1,0,1; frame_done=1 only on the 8th shift edge.
- LOAD 8'h81, ROR x1 -> 8'hC0; ROL x2 -> 8'h03; LOAD 8'h90, ASR x2 -> 8'hE4.
- Frame interruption: LOAD 0; SHR x5 with sin_l=1, then en=0 for 3 cycles, then SHR x3 -> q=8'hFF, and frame_done pulses on the 8th shift only. Repeating with LOAD inserted after the 5th shift -> no pulse until 8 further shifts.
- Mid-operation reset: after SHL x6 from q=8'h00 with sin_r=1, drive rst=0 for one edge -> q=RESET_VALUE, counter 0; then 8 shifts -> frame_done at the 8th, not the 2nd.
- CLR vs reset: instantiate with RESET_VALUE=8'h3C; reset -> q=8'h3C; mode=111 -> q=8'h00; mode=000 for 4 cycles -> q unchanged, frame_done=0.
